// File: rtl/inst_encoder.sv
// inst_encoder: encodes LA32R instruction requests into 32-bit words and
// buffers them in a 2-entry FIFO with valid/ready handshakes on both sides.
// Optional feature macro: INST_ENC_ILLEGAL_TRAP_EN -- when defined, illegal
// type codes are enqueued as a zero word flagged on inst_err_o; otherwise
// they are accepted and silently dropped and inst_err_o does not exist.
module inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [4:0]  req_type_i,
  input  logic [4:0]  req_rd_i,
  input  logic [4:0]  req_rj_i,
  input  logic [4:0]  req_rk_i,
  input  logic [25:0] req_imm_i,
  input  logic        flush_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
`ifdef INST_ENC_ILLEGAL_TRAP_EN
  output logic        inst_err_o,
`endif
  output logic [15:0] enc_cnt_o
);

  localparam int unsigned INST_W   = 32;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned NUM_LEGAL = 20;

  // Type codes
  localparam logic [4:0] T_ADD_W  = 5'd0;
  localparam logic [4:0] T_SUB_W  = 5'd1;
  localparam logic [4:0] T_SLT    = 5'd2;
  localparam logic [4:0] T_SLTU   = 5'd3;
  localparam logic [4:0] T_NOR    = 5'd4;
  localparam logic [4:0] T_AND    = 5'd5;
  localparam logic [4:0] T_OR     = 5'd6;
  localparam logic [4:0] T_XOR    = 5'd7;
  localparam logic [4:0] T_SLLI_W = 5'd8;
  localparam logic [4:0] T_SRLI_W = 5'd9;
  localparam logic [4:0] T_SRAI_W = 5'd10;
  localparam logic [4:0] T_ADDI_W = 5'd11;
  localparam logic [4:0] T_LD_W   = 5'd12;
  localparam logic [4:0] T_ST_W   = 5'd13;
  localparam logic [4:0] T_JIRL   = 5'd14;
  localparam logic [4:0] T_B      = 5'd15;
  localparam logic [4:0] T_BL     = 5'd16;
  localparam logic [4:0] T_BEQ    = 5'd17;
  localparam logic [4:0] T_BNE    = 5'd18;
  localparam logic [4:0] T_LU12I  = 5'd19;

  logic [INST_W-1:0] mem [DEPTH];
`ifdef INST_ENC_ILLEGAL_TRAP_EN
  logic              err_mem [DEPTH];
`endif
  logic              wr_ptr;
  logic              rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [15:0]       enc_cnt;

  logic              full_c;
  logic              empty_c;
  logic              pop_c;
  logic              accept_c;
  logic              legal_c;
  logic              push_c;
  logic [INST_W-1:0] enc_c;

  logic [INST_W-1:0] fmt_3r_c;
  logic [INST_W-1:0] fmt_sh_c;
  logic [INST_W-1:0] fmt_i12_c;
  logic [INST_W-1:0] fmt_i16_c;
  logic [INST_W-1:0] fmt_i26_c;
  logic [INST_W-1:0] fmt_lu_c;

  // FIFO status and handshake qualification
  always_comb begin
    full_c       = (count == CNT_W'(DEPTH));
    empty_c      = (count == '0);
    inst_valid_o = rst_n & ~empty_c;
    pop_c        = inst_valid_o & inst_ready_i & ~flush_i;
    req_ready_o  = rst_n & ~flush_i & (~full_c | pop_c);
    accept_c     = req_valid_i & req_ready_o;
    legal_c      = (req_type_i < 5'(NUM_LEGAL));
`ifdef INST_ENC_ILLEGAL_TRAP_EN
    push_c       = accept_c;
`else
    push_c       = accept_c & legal_c;
`endif
  end

  // Instruction field packing per format and base selection by type
  always_comb begin
    fmt_3r_c  = {17'b0, req_rk_i, req_rj_i, req_rd_i};
    fmt_sh_c  = {17'b0, req_imm_i[4:0], req_rj_i, req_rd_i};
    fmt_i12_c = {10'b0, req_imm_i[11:0], req_rj_i, req_rd_i};
    fmt_i16_c = {6'b0, req_imm_i[15:0], req_rj_i, req_rd_i};
    fmt_i26_c = {6'b0, req_imm_i[15:0], req_imm_i[25:16]};
    fmt_lu_c  = {7'b0, req_imm_i[19:0], req_rd_i};
    enc_c     = '0;
    case (req_type_i)
      T_ADD_W:  enc_c = 32'h0010_0000 | fmt_3r_c;
      T_SUB_W:  enc_c = 32'h0011_0000 | fmt_3r_c;
      T_SLT:    enc_c = 32'h0012_0000 | fmt_3r_c;
      T_SLTU:   enc_c = 32'h0012_8000 | fmt_3r_c;
      T_NOR:    enc_c = 32'h0014_0000 | fmt_3r_c;
      T_AND:    enc_c = 32'h0014_8000 | fmt_3r_c;
      T_OR:     enc_c = 32'h0015_0000 | fmt_3r_c;
      T_XOR:    enc_c = 32'h0015_8000 | fmt_3r_c;
      T_SLLI_W: enc_c = 32'h0040_8000 | fmt_sh_c;
      T_SRLI_W: enc_c = 32'h0044_8000 | fmt_sh_c;
      T_SRAI_W: enc_c = 32'h0048_8000 | fmt_sh_c;
      T_ADDI_W: enc_c = 32'h0280_0000 | fmt_i12_c;
      T_LD_W:   enc_c = 32'h2880_0000 | fmt_i12_c;
      T_ST_W:   enc_c = 32'h2980_0000 | fmt_i12_c;
      T_JIRL:   enc_c = 32'h4C00_0000 | fmt_i16_c;
      T_B:      enc_c = 32'h5000_0000 | fmt_i26_c;
      T_BL:     enc_c = 32'h5400_0000 | fmt_i26_c;
      T_BEQ:    enc_c = 32'h5800_0000 | fmt_i16_c;
      T_BNE:    enc_c = 32'h5C00_0000 | fmt_i16_c;
      T_LU12I:  enc_c = 32'h1400_0000 | fmt_lu_c;
      default:  enc_c = '0;
    endcase
  end

  // Pointer and occupancy tracking; flush and reset both empty the FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= ~wr_ptr;
      if (pop_c)  rd_ptr <= ~rd_ptr;
      count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Entry storage, written with the encoded word at accept time
  always_ff @(posedge clk) begin
    if (push_c && !flush_i) begin
      mem[wr_ptr] <= enc_c;
`ifdef INST_ENC_ILLEGAL_TRAP_EN
      err_mem[wr_ptr] <= ~legal_c;
`endif
    end
  end

  // Delivered-word counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_cnt <= '0;
    end else if (pop_c) begin
      enc_cnt <= enc_cnt + 16'd1;
    end
  end

  // Head-of-FIFO outputs, forced to zero while nothing is presented
  always_comb begin
    inst_o     = inst_valid_o ? mem[rd_ptr] : '0;
`ifdef INST_ENC_ILLEGAL_TRAP_EN
    inst_err_o = inst_valid_o & err_mem[rd_ptr];
`endif
    enc_cnt_o  = enc_cnt;
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: table of single-word encodings plus
// hand-written backpressure, flush, illegal-type, wrap and reset sequences.
module tb_inst_encoder;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [4:0]  req_type_i;
  logic [4:0]  req_rd_i;
  logic [4:0]  req_rj_i;
  logic [4:0]  req_rk_i;
  logic [25:0] req_imm_i;
  logic        flush_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
`ifdef INST_ENC_ILLEGAL_TRAP_EN
  logic        inst_err_o;
`endif
  logic [15:0] enc_cnt_o;

  inst_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_type_i   (req_type_i),
    .req_rd_i     (req_rd_i),
    .req_rj_i     (req_rj_i),
    .req_rk_i     (req_rk_i),
    .req_imm_i    (req_imm_i),
    .flush_i      (flush_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
`ifdef INST_ENC_ILLEGAL_TRAP_EN
    .inst_err_o   (inst_err_o),
`endif
    .enc_cnt_o    (enc_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  t;
    logic [4:0]  rd;
    logic [4:0]  rj;
    logic [4:0]  rk;
    logic [25:0] imm;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int          total;
  int          passed;
  logic [15:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %08h want %08h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] t, input logic [4:0] rd, input logic [4:0] rj,
                       input logic [4:0] rk, input logic [25:0] imm);
    req_type_i = t;
    req_rd_i   = rd;
    req_rj_i   = rj;
    req_rk_i   = rk;
    req_imm_i  = imm;
  endtask

  // One request into an idle FIFO, consumer always ready
  task automatic send_one(input vec_t v, input string name);
    drive(v.t, v.rd, v.rj, v.rk, v.imm);
    req_valid_i  = 1'b1;
    inst_ready_i = 1'b1;
    #1;
    chk({name, " req_ready"}, 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    #1;
    chk({name, " valid"}, 32'(inst_valid_o), 32'd1);
    chk({name, " word"}, inst_o, v.exp);
`ifdef INST_ENC_ILLEGAL_TRAP_EN
    chk({name, " err"}, 32'(inst_err_o), 32'd0);
`endif
    tick();
    exp_cnt = exp_cnt + 16'd1;
    chk({name, " cnt"}, 32'(enc_cnt_o), 32'(exp_cnt));
  endtask

  initial begin
    int n;
    total   = 0;
    passed  = 0;
    exp_cnt = 16'd0;

    vecs[0]  = '{5'd0,  5'd1,  5'd2,  5'd3,  26'h0,       32'h00100C41};
    vecs[1]  = '{5'd1,  5'd31, 5'd31, 5'd31, 26'h3FFFFFF, 32'h00117FFF};
    vecs[2]  = '{5'd2,  5'd4,  5'd5,  5'd6,  26'h0,       32'h001218A4};
    vecs[3]  = '{5'd3,  5'd0,  5'd0,  5'd1,  26'h0,       32'h00128400};
    vecs[4]  = '{5'd4,  5'd7,  5'd8,  5'd9,  26'h0,       32'h00142507};
    vecs[5]  = '{5'd5,  5'd10, 5'd11, 5'd12, 26'h0,       32'h0014B16A};
    vecs[6]  = '{5'd6,  5'd1,  5'd1,  5'd1,  26'h0,       32'h00150421};
    vecs[7]  = '{5'd7,  5'd2,  5'd3,  5'd4,  26'h0,       32'h00159062};
    vecs[8]  = '{5'd8,  5'd1,  5'd2,  5'd31, 26'h3F,      32'h0040FC41};
    vecs[9]  = '{5'd9,  5'd3,  5'd4,  5'd31, 26'h5,       32'h00449483};
    vecs[10] = '{5'd10, 5'd5,  5'd6,  5'd31, 26'h3FFFFFF, 32'h0048FCC5};
    vecs[11] = '{5'd11, 5'd4,  5'd0,  5'd9,  26'h7FF,     32'h029FFC04};
    vecs[12] = '{5'd12, 5'd1,  5'd2,  5'd0,  26'h1800,    32'h28A00041};
    vecs[13] = '{5'd13, 5'd3,  5'd4,  5'd0,  26'hFFF,     32'h29BFFC83};
    vecs[14] = '{5'd14, 5'd1,  5'd1,  5'd7,  26'h1,       32'h4C000421};
    vecs[15] = '{5'd15, 5'd7,  5'd9,  5'd3,  26'h1,       32'h50000400};
    vecs[16] = '{5'd16, 5'd0,  5'd0,  5'd0,  26'h3FFFFFF, 32'h57FFFFFF};
    vecs[17] = '{5'd17, 5'd2,  5'd3,  5'd0,  26'hFFFF,    32'h5BFFFC62};
    vecs[18] = '{5'd18, 5'd0,  5'd0,  5'd0,  26'h8000,    32'h5E000000};
    vecs[19] = '{5'd19, 5'd5,  5'd31, 5'd31, 26'hFFFFF,   32'h15FFFFE5};
    vecs[20] = '{5'd15, 5'd0,  5'd0,  5'd0,  26'h10000,   32'h50000001};

    // Reset state
    rst_n        = 1'b0;
    req_valid_i  = 1'b0;
    flush_i      = 1'b0;
    inst_ready_i = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 5'd0, 26'h0);
    tick();
    tick();
    chk("rst valid", 32'(inst_valid_o), 32'd0);
    chk("rst word", inst_o, 32'd0);
    chk("rst ready", 32'(req_ready_o), 32'd0);
    chk("rst cnt", 32'(enc_cnt_o), 32'd0);
`ifdef INST_ENC_ILLEGAL_TRAP_EN
    chk("rst err", 32'(inst_err_o), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("post-rst ready", 32'(req_ready_o), 32'd1);
    tick();

    // Table of single-word encodings
    for (int i = 0; i < NV; i++) send_one(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: three back-to-back requests, consumer stalled
    inst_ready_i = 1'b0;
    req_valid_i  = 1'b1;
    drive(5'd0, 5'd1, 5'd2, 5'd3, 26'h0);
    #1;
    chk("bp ready1", 32'(req_ready_o), 32'd1);
    tick();
    drive(5'd11, 5'd4, 5'd0, 5'd0, 26'h7FF);
    #1;
    chk("bp ready2", 32'(req_ready_o), 32'd1);
    chk("bp head1", inst_o, 32'h00100C41);
    tick();
    drive(5'd19, 5'd5, 5'd0, 5'd0, 26'hFFFFF);
    #1;
    chk("bp full ready", 32'(req_ready_o), 32'd0);
    chk("bp hold1", inst_o, 32'h00100C41);
    tick();
    chk("bp hold1b", inst_o, 32'h00100C41);
    chk("bp full ready2", 32'(req_ready_o), 32'd0);
    inst_ready_i = 1'b1;
    #1;
    chk("bp pop ready", 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    #1;
    chk("bp word2", inst_o, 32'h029FFC04);
    tick();
    chk("bp word3", inst_o, 32'h15FFFFE5);
    tick();
    chk("bp drained", 32'(inst_valid_o), 32'd0);
    exp_cnt = exp_cnt + 16'd3;
    chk("bp cnt", 32'(enc_cnt_o), 32'(exp_cnt));

    // Flush with a full FIFO and a simultaneous request
    inst_ready_i = 1'b0;
    req_valid_i  = 1'b1;
    drive(5'd6, 5'd1, 5'd1, 5'd1, 26'h0);
    tick();
    tick();
    chk("fl full valid", 32'(inst_valid_o), 32'd1);
    flush_i      = 1'b1;
    inst_ready_i = 1'b1;
    drive(5'd7, 5'd2, 5'd3, 5'd4, 26'h0);
    #1;
    chk("fl ready", 32'(req_ready_o), 32'd0);
    tick();
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    #1;
    chk("fl valid", 32'(inst_valid_o), 32'd0);
    chk("fl cnt", 32'(enc_cnt_o), 32'(exp_cnt));
    tick();
    chk("fl not taken", 32'(inst_valid_o), 32'd0);

    // Illegal type code
    req_valid_i = 1'b1;
    drive(5'd25, 5'd1, 5'd2, 5'd3, 26'h3FFFFFF);
    #1;
    chk("ill ready", 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    #1;
`ifdef INST_ENC_ILLEGAL_TRAP_EN
    chk("ill valid", 32'(inst_valid_o), 32'd1);
    chk("ill word", inst_o, 32'd0);
    chk("ill err", 32'(inst_err_o), 32'd1);
    tick();
    exp_cnt = exp_cnt + 16'd1;
`else
    chk("ill valid", 32'(inst_valid_o), 32'd0);
    tick();
`endif
    chk("ill cnt", 32'(enc_cnt_o), 32'(exp_cnt));

    // Stream until the counter reaches 0xFFFF, then wrap it
    n = 32'(16'hFFFF - exp_cnt);
    drive(5'd0, 5'd1, 5'd2, 5'd3, 26'h0);
    req_valid_i = 1'b1;
    for (int i = 0; i < n; i++) tick();
    req_valid_i = 1'b0;
    tick();
    exp_cnt = 16'hFFFF;
    chk("wrap pre cnt", 32'(enc_cnt_o), 32'h0000FFFF);
    chk("wrap pre idle", 32'(inst_valid_o), 32'd0);
    send_one(vecs[15], "wrap");

    // Reset in the middle of a stream discards buffered words
    inst_ready_i = 1'b0;
    req_valid_i  = 1'b1;
    drive(5'd2, 5'd4, 5'd5, 5'd6, 26'h0);
    tick();
    tick();
    req_valid_i = 1'b0;
    #1;
    chk("mr buffered", 32'(inst_valid_o), 32'd1);
    rst_n        = 1'b0;
    inst_ready_i = 1'b1;
    #1;
    chk("mr valid", 32'(inst_valid_o), 32'd0);
    chk("mr word", inst_o, 32'd0);
    chk("mr ready", 32'(req_ready_o), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr post valid", 32'(inst_valid_o), 32'd0);
    chk("mr post ready", 32'(req_ready_o), 32'd1);
    chk("mr post cnt", 32'(enc_cnt_o), 32'd0);
    tick();
    tick();
    chk("mr no deliver", 32'(inst_valid_o), 32'd0);
    chk("mr cnt held", 32'(enc_cnt_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
